bus_arbiter_mux: RTL and testbench

//  Parametrised, registered successor to the one-hot-select bus multiplexer.

---
 rtl/bus_arbiter_mux.sv | 115 +++++++++++
 tb/tb_bus_arbiter_mux.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_mux.sv
// Registered bus arbiter and multiplexer: grants one requesting source per cycle
// (round-robin or fixed priority, with optional lock) and drives its word onto the bus.
module bus_arbiter_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int SELW  = 5,
  parameter bit RR    = 1'b1
) (
  input  logic                    clock_i,
  input  logic                    clear_i,
  input  logic [NSRC-1:0]         req_i,
  input  logic [NSRC*WIDTH-1:0]   src_data_i,
  input  logic                    lock_i,
  output logic [NSRC-1:0]         grant_o,
  output logic [WIDTH-1:0]        bus_out_o,
  output logic                    bus_valid_o,
  output logic [SELW-1:0]         owner_idx_o
);

  logic [NSRC-1:0]  grant_q, grant_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  owner_q, owner_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             owner_req;
  logic             locked;
  logic [NSRC-1:0]  above_mask;
  logic [SELW:0]    hi_pick, lo_pick, rr_pick;
  logic             win_found;
  logic [SELW-1:0]  win_idx;

  // Returns {found, index} of the lowest set bit of v.
  function automatic logic [SELW:0] find_first(input logic [NSRC-1:0] v);
    find_first = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) find_first = {1'b1, SELW'(i)};
    end
  endfunction

  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (owner_q == SELW'(i)) owner_req = req_i[i];
    end
  end

  assign locked = lock_i & valid_q & owner_req;

  // Round-robin: prefer requesters above the pointer, otherwise wrap to the lowest.
  always_comb begin
    above_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      above_mask[i] = (SELW'(i) > ptr_q);
    end
  end

  assign hi_pick = find_first(req_i & above_mask);
  assign lo_pick = find_first(req_i);
  assign rr_pick = hi_pick[SELW] ? hi_pick : lo_pick;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (locked) begin
      win_found = 1'b1;
      win_idx   = owner_q;
    end else if (RR) begin
      win_found = rr_pick[SELW];
      win_idx   = rr_pick[SELW-1:0];
    end else begin
      win_found = lo_pick[SELW];
      win_idx   = lo_pick[SELW-1:0];
    end
  end

  always_comb begin
    grant_d = '0;
    bus_d   = '0;
    valid_d = 1'b0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (win_found) begin
      valid_d = 1'b1;
      owner_d = win_idx;
      ptr_d   = win_idx;
      for (int i = 0; i < NSRC; i++) begin
        grant_d[i] = (win_idx == SELW'(i));
        if (win_idx == SELW'(i)) bus_d = src_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      grant_q <= '0;
      bus_q   <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
      ptr_q   <= SELW'(NSRC - 1);
    end else begin
      grant_q <= grant_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_o     = grant_q;
  assign bus_out_o   = bus_q;
  assign bus_valid_o = valid_q;
  assign owner_idx_o = owner_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: round-robin and fixed-priority instances share stimulus
// and are compared each cycle against a scan-based reference model.
module tb_bus_arbiter_mux;
  localparam int WIDTH = 32;
  localparam int NSRC  = 24;
  localparam int SELW  = 5;
  localparam logic [NSRC-1:0] ALL = {NSRC{1'b1}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  clear, lock;
  logic [NSRC-1:0]       req;
  logic [NSRC*WIDTH-1:0] src;

  logic [NSRC-1:0]  g_rr, g_fp;
  logic [WIDTH-1:0] b_rr, b_fp;
  logic             v_rr, v_fp;
  logic [SELW-1:0]  o_rr, o_fp;

  bus_arbiter_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .RR(1'b1)) u_rr (
    .clock_i(clk), .clear_i(clear), .req_i(req), .src_data_i(src), .lock_i(lock),
    .grant_o(g_rr), .bus_out_o(b_rr), .bus_valid_o(v_rr), .owner_idx_o(o_rr));

  bus_arbiter_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .RR(1'b0)) u_fp (
    .clock_i(clk), .clear_i(clear), .req_i(req), .src_data_i(src), .lock_i(lock),
    .grant_o(g_fp), .bus_out_o(b_fp), .bus_valid_o(v_fp), .owner_idx_o(o_fp));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state, index 0 = fixed priority, 1 = round-robin
  int          m_own[2];
  int          m_ptr[2];
  bit          m_val[2];
  logic [31:0] m_bus[2];

  task automatic model_edge(input int m);
    int win;
    win = -1;
    if (clear) begin
      m_own[m] = 0; m_ptr[m] = NSRC - 1; m_val[m] = 1'b0; m_bus[m] = '0;
      return;
    end
    if (lock && m_val[m] && req[m_own[m]]) win = m_own[m];
    else if (m == 1) begin
      for (int k = 1; k <= NSRC; k++) begin
        int idx;
        idx = (m_ptr[m] + k) % NSRC;
        if (req[idx]) begin win = idx; break; end
      end
    end else begin
      for (int i = 0; i < NSRC; i++) if (req[i]) begin win = i; break; end
    end
    if (win >= 0) begin
      m_own[m] = win; m_ptr[m] = win; m_val[m] = 1'b1;
      m_bus[m] = src[win*WIDTH +: WIDTH];
    end else begin
      m_val[m] = 1'b0; m_bus[m] = '0;
    end
  endtask

  function automatic logic [31:0] exp_grant(input int m);
    return m_val[m] ? (32'd1 << m_own[m]) : 32'd0;
  endfunction

  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    chk("rr_grant", 32'(g_rr), exp_grant(1));
    chk("rr_bus",   b_rr,      m_bus[1]);
    chk("rr_valid", 32'(v_rr), 32'(m_val[1]));
    chk("rr_owner", 32'(o_rr), 32'(m_own[1]));
    chk("fp_grant", 32'(g_fp), exp_grant(0));
    chk("fp_bus",   b_fp,      m_bus[0]);
    chk("fp_valid", 32'(v_fp), 32'(m_val[0]));
    chk("fp_owner", 32'(o_fp), 32'(m_own[0]));
  endtask

  initial begin
    clear = 1'b1; lock = 1'b0; req = ALL;
    for (int i = 0; i < NSRC; i++) src[i*WIDTH +: WIDTH] = 32'hA000_0000 + 32'(i);
    m_own = '{0, 0}; m_ptr = '{NSRC-1, NSRC-1}; m_val = '{0, 0}; m_bus = '{0, 0};

    // T1 reset
    step(); step();
    chk("t1_clr_grant", 32'(g_rr), 32'd0);
    chk("t1_clr_bus",   b_rr,      32'd0);
    clear = 1'b0;
    step();
    chk("t1_grant", 32'(g_rr), 32'h000001);
    chk("t1_bus",   b_rr,      32'hA000_0000);

    // T2 round-robin rotation, from a fresh pointer
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 26; i++) begin
      step();
      chk("t2_owner", 32'(o_rr), 32'(i % NSRC));
      chk("t2_bus",   b_rr,      32'hA000_0000 + 32'(i % NSRC));
      chk("t2_fp_owner", 32'(o_fp), 32'd0);
    end

    // T3 fixed priority
    req = 24'h800014;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_owner", 32'(o_fp), 32'd2);
      chk("t3_no4_23", 32'(g_fp & 24'h800010), 32'd0);
    end

    // T4 lock
    req = 24'h000020; step();
    lock = 1'b1; req = ALL;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_hold", 32'(o_rr), 32'd5);
    end
    req[5] = 1'b0; step();
    chk("t4_release", 32'(o_rr), 32'd6);
    lock = 1'b0;

    // T5 idle and resume
    req = 24'h800000; step();
    req = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t5_idle_valid", 32'(v_rr), 32'd0);
      chk("t5_idle_owner", 32'(o_rr), 32'd23);
    end
    req = 24'h000003; step();
    chk("t5_resume", 32'(o_rr), 32'd0);

    // T6 reset mid-lock
    req = 24'h000200; step();
    lock = 1'b1; req = ALL; step();
    chk("t6_locked", 32'(o_rr), 32'd9);
    clear = 1'b1; step();
    chk("t6_clr_grant", 32'(g_rr), 32'd0);
    chk("t6_clr_owner", 32'(o_rr), 32'd0);
    clear = 1'b0; step();
    chk("t6_after", 32'(o_rr), 32'd0);

    // Random phase
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 5))
        0:       req = '0;
        1:       req = ALL;
        2:       req = NSRC'(1) << $urandom_range(0, NSRC - 1);
        default: req = NSRC'($urandom) & NSRC'($urandom);
      endcase
      lock  = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 40) == 0);
      for (int i = 0; i < NSRC; i++) src[i*WIDTH +: WIDTH] = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
